// File: rtl/parity_link_arbiter_if.sv
// rtl/parity_link_arbiter_if.sv - request/response and serial-line bundle of the parity link arbiter
interface parity_link_arbiter_if;
  logic       Req0;
  logic [7:0] Din0;
  logic       Req1;
  logic [7:0] Din1;
  logic       Ack0;
  logic       Ack1;
  logic       SDout;
  logic       Frame;
  logic       GntId;
  logic       Busy;

  modport master (
    output Req0, Din0, Req1, Din1,
    input  Ack0, Ack1, SDout, Frame, GntId, Busy
  );

  modport slave (
    input  Req0, Din0, Req1, Din1,
    output Ack0, Ack1, SDout, Frame, GntId, Busy
  );
endinterface

// File: rtl/parity_link_arbiter.sv
// rtl/parity_link_arbiter.sv - two-requester round-robin arbiter serialising bytes MSB first plus even parity
module parity_link_arbiter #(
  parameter int GAP = 1
) (
  input logic                 Clk,
  input logic                 Rst_n,
  parity_link_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR, S_GAP} state_t;

  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t     state_q, state_n;
  logic [7:0] data_q, data_n;
  logic [2:0] bit_cnt_q, bit_cnt_n;
  logic [3:0] gap_cnt_q, gap_cnt_n;
  logic       last_q, last_n;
  logic       ack0_q, ack0_n;
  logic       ack1_q, ack1_n;
  logic       sd_q, sd_n;
  logic       frame_q, frame_n;
  logic       gnt_q, gnt_n;
  logic       busy_q, busy_n;
  logic       win;
  logic [7:0] win_byte;

  // Alternate on contention; a lone requester always wins.
  assign win      = (bus.Req0 && bus.Req1) ? ~last_q : bus.Req1;
  assign win_byte = win ? bus.Din1 : bus.Din0;

  always_comb begin
    state_n   = state_q;
    data_n    = data_q;
    bit_cnt_n = bit_cnt_q;
    gap_cnt_n = gap_cnt_q;
    last_n    = last_q;
    gnt_n     = gnt_q;
    ack0_n    = 1'b0;
    ack1_n    = 1'b0;
    sd_n      = 1'b0;
    frame_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.Req0 || bus.Req1) begin
          state_n   = S_DATA;
          data_n    = win_byte;
          bit_cnt_n = 3'd0;
          last_n    = win;
          gnt_n     = win;
          ack0_n    = ~win;
          ack1_n    = win;
          sd_n      = win_byte[7];
          frame_n   = 1'b1;
        end
      end
      S_DATA: begin
        frame_n = 1'b1;
        if (bit_cnt_q == 3'd7) begin
          state_n   = S_PAR;
          bit_cnt_n = 3'd0;
          sd_n      = ^data_q;
        end else begin
          bit_cnt_n = bit_cnt_q + 3'd1;
          sd_n      = data_q[3'd6 - bit_cnt_q];
        end
      end
      S_PAR: begin
        gap_cnt_n = 4'd0;
        state_n   = (GAP == 0) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_n   = S_IDLE;
          gap_cnt_n = 4'd0;
        end else begin
          gap_cnt_n = gap_cnt_q + 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= 8'd0;
      bit_cnt_q <= 3'd0;
      gap_cnt_q <= 4'd0;
      last_q    <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      sd_q      <= 1'b0;
      frame_q   <= 1'b0;
      gnt_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      data_q    <= data_n;
      bit_cnt_q <= bit_cnt_n;
      gap_cnt_q <= gap_cnt_n;
      last_q    <= last_n;
      ack0_q    <= ack0_n;
      ack1_q    <= ack1_n;
      sd_q      <= sd_n;
      frame_q   <= frame_n;
      gnt_q     <= gnt_n;
      busy_q    <= busy_n;
    end
  end

  assign bus.Ack0  = ack0_q;
  assign bus.Ack1  = ack1_q;
  assign bus.SDout = sd_q;
  assign bus.Frame = frame_q;
  assign bus.GntId = gnt_q;
  assign bus.Busy  = busy_q;

endmodule

// File: tb/tb_parity_link_arbiter.sv
// tb/tb_parity_link_arbiter.sv - randomized self-checking bench for parity_link_arbiter at GAP 1, 2 and 0
module tb_parity_link_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req0_v, req1_v;
  logic [7:0] din0_v [3];
  logic [7:0] din1_v [3];
  wire  [2:0] ack0_v, ack1_v, sd_v, fr_v, gnt_v, busy_v;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int model_last [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : inst
      parity_link_arbiter_if ifc ();
      assign ifc.Req0   = req0_v[g];
      assign ifc.Req1   = req1_v[g];
      assign ifc.Din0   = din0_v[g];
      assign ifc.Din1   = din1_v[g];
      assign ack0_v[g]  = ifc.Ack0;
      assign ack1_v[g]  = ifc.Ack1;
      assign sd_v[g]    = ifc.SDout;
      assign fr_v[g]    = ifc.Frame;
      assign gnt_v[g]   = ifc.GntId;
      assign busy_v[g]  = ifc.Busy;
      parity_link_arbiter #(.GAP(g == 0 ? 1 : (g == 1 ? 2 : 0))) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (ifc)
      );
    end
  endgenerate

  function automatic int gap_of(int i);
    return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) model_last[i] = 1;
    rst_n = 1'b1;
  endtask

  // Reference arbitration: decide winner and byte from what the requesters present now.
  task automatic wait_grant(input int i, output bit ok, output int exp_id, output logic [7:0] exp_byte);
    bit r0, r1;
    r0 = req0_v[i];
    r1 = req1_v[i];
    exp_id   = (r0 && r1) ? (1 - model_last[i]) : (r1 ? 1 : 0);
    exp_byte = (exp_id == 1) ? din1_v[i] : din0_v[i];
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (ack0_v[i] || ack1_v[i]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL grant_timeout inst=%0d actual=no_ack required=ack within 40 cycles", i);
    end else begin
      model_last[i] = exp_id;
    end
  endtask

  task automatic drop_winner(input int i, input int id);
    if (id == 1) req1_v[i] = 1'b0;
    else         req0_v[i] = 1'b0;
  endtask

  // Entered at the first cycle of a frame; leaves one cycle after the idle cycle that follows it.
  task automatic check_frame(input int i, input int id, input logic [7:0] b, input bit corrupt, input string tag);
    int   p;
    logic exp_bit;
    p = $countones(b) % 2;
    checks++;
    if (ack0_v[i] !== (id == 0) || ack1_v[i] !== (id == 1)) begin
      errors++;
      $display("FAIL %s_ack inst=%0d actual ack0=%b ack1=%b required winner=%0d", tag, i, ack0_v[i], ack1_v[i], id);
    end
    checks++;
    if (gnt_v[i] !== 1'(id)) begin
      errors++;
      $display("FAIL %s_gnt inst=%0d actual=%b required=%0d", tag, i, gnt_v[i], id);
    end
    for (int t = 0; t < 9; t++) begin
      exp_bit = (t < 8) ? b[7 - t] : 1'(p);
      checks++;
      if (sd_v[i] !== exp_bit || fr_v[i] !== 1'b1 || busy_v[i] !== 1'b1 ||
          (t > 0 && (ack0_v[i] || ack1_v[i]))) begin
        errors++;
        $display("FAIL %s_bit%0d inst=%0d actual sd=%b fr=%b busy=%b ack=%b%b required sd=%b fr=1 busy=1",
                 tag, t, i, sd_v[i], fr_v[i], busy_v[i], ack1_v[i], ack0_v[i], exp_bit);
      end
      if (corrupt && t == 4) begin
        din0_v[i] = ~din0_v[i];
        din1_v[i] = 8'($urandom);
      end
      @(negedge clk);
    end
    for (int t = 0; t < gap_of(i); t++) begin
      checks++;
      if (sd_v[i] !== 1'b0 || fr_v[i] !== 1'b0 || busy_v[i] !== 1'b1 || ack0_v[i] || ack1_v[i]) begin
        errors++;
        $display("FAIL %s_gap%0d inst=%0d actual sd=%b fr=%b busy=%b required sd=0 fr=0 busy=1",
                 tag, t, i, sd_v[i], fr_v[i], busy_v[i]);
      end
      @(negedge clk);
    end
    checks++;
    if (sd_v[i] !== 1'b0 || fr_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle inst=%0d actual sd=%b fr=%b busy=%b required all 0", tag, i, sd_v[i], fr_v[i], busy_v[i]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req0_v = '0;
    req1_v = '0;
    for (int i = 0; i < 3; i++) begin
      din0_v[i] = 8'h00;
      din1_v[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ack0_v[i], ack1_v[i], sd_v[i], fr_v[i], gnt_v[i], busy_v[i]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs inst=%0d actual=%b required=000000", i,
                 {ack0_v[i], ack1_v[i], sd_v[i], fr_v[i], gnt_v[i], busy_v[i]});
      end
    end
    for (int i = 0; i < 3; i++) model_last[i] = 1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_a5();
    bit ok; int id; logic [7:0] b;
    din0_v[0] = 8'hA5;
    req0_v[0] = 1'b1;
    wait_grant(0, ok, id, b);
    if (ok) begin
      drop_winner(0, id);
      check_frame(0, id, b, 1'b0, "single_a5");
    end
  endtask

  task automatic test_contention();
    bit ok; int id; logic [7:0] b;
    apply_reset();
    din0_v[0] = 8'h01;
    din1_v[0] = 8'h80;
    req0_v[0] = 1'b1;
    req1_v[0] = 1'b1;
    for (int f = 0; f < 2; f++) begin
      wait_grant(0, ok, id, b);
      if (!ok) break;
      drop_winner(0, id);
      check_frame(0, id, b, 1'b0, "contention");
    end
    req0_v[0] = 1'b0;
    req1_v[0] = 1'b0;
  endtask

  task automatic run_held(input int i, input int nframes, input string tag);
    bit ok; int id; logic [7:0] b; int prev;
    prev = -1;
    for (int f = 0; f < nframes; f++) begin
      wait_grant(i, ok, id, b);
      if (!ok) break;
      if (prev >= 0) begin
        checks++;
        if (cyc - prev !== 10 + gap_of(i)) begin
          errors++;
          $display("FAIL %s_period inst=%0d actual=%0d required=%0d", tag, i, cyc - prev, 10 + gap_of(i));
        end
      end
      prev = cyc;
      if (f == nframes - 1) begin
        req0_v[i] = 1'b0;
        req1_v[i] = 1'b0;
      end
      check_frame(i, id, b, 1'b0, tag);
    end
    req0_v[i] = 1'b0;
    req1_v[i] = 1'b0;
  endtask

  task automatic test_back_to_back();
    din0_v[1] = 8'($urandom);
    din1_v[1] = 8'($urandom);
    req0_v[1] = 1'b1;
    req1_v[1] = 1'b1;
    run_held(1, 4, "rr_gap2");
    repeat (3) @(negedge clk);
    din1_v[2] = 8'hFF;
    req1_v[2] = 1'b1;
    run_held(2, 3, "gap0_ff");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_din_change();
    bit ok; int id; logic [7:0] b;
    din0_v[0] = 8'h3C;
    req0_v[0] = 1'b1;
    wait_grant(0, ok, id, b);
    if (ok) begin
      drop_winner(0, id);
      check_frame(0, id, b, 1'b1, "din_change");
    end
  endtask

  task automatic test_reset_midframe();
    bit ok; int id; logic [7:0] b; int acks;
    din0_v[0] = 8'($urandom);
    req0_v[0] = 1'b1;
    wait_grant(0, ok, id, b);
    if (!ok) return;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (sd_v[0] !== 1'b0 || fr_v[0] !== 1'b0 || busy_v[0] !== 1'b0 || ack0_v[0] || ack1_v[0]) begin
      errors++;
      $display("FAIL midreset_abort actual sd=%b fr=%b busy=%b ack=%b%b required all 0",
               sd_v[0], fr_v[0], busy_v[0], ack1_v[0], ack0_v[0]);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) model_last[i] = 1;
    rst_n = 1'b1;
    wait_grant(0, ok, id, b);
    if (!ok) return;
    drop_winner(0, id);
    check_frame(0, id, b, 1'b0, "post_reset");
    acks = 0;
    for (int n = 0; n < 20; n++) begin
      if (ack0_v[0] || ack1_v[0]) acks++;
      @(negedge clk);
    end
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL post_reset_extra_ack actual=%0d required=0", acks);
    end
  endtask

  task automatic test_random();
    bit ok; int id; logic [7:0] b; int frames; int pat;
    for (int i = 0; i < 3; i++) begin
      frames = 0;
      while (frames < 10 || req0_v[i] || req1_v[i]) begin
        if (!req0_v[i] && !req1_v[i] && frames < 10) begin
          pat = $urandom_range(3, 1);
          if (pat[0]) begin din0_v[i] = 8'($urandom); req0_v[i] = 1'b1; end
          if (pat[1]) begin din1_v[i] = 8'($urandom); req1_v[i] = 1'b1; end
        end
        wait_grant(i, ok, id, b);
        if (!ok) begin
          req0_v[i] = 1'b0;
          req1_v[i] = 1'b0;
          break;
        end
        drop_winner(i, id);
        check_frame(i, id, b, 1'($urandom_range(1, 0)), "random");
        frames++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_contention();
    test_back_to_back();
    test_din_change();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/parity_link_arbiter.md
PARITY_LINK_ARBITER -- requirements
Module: parity_link_arbiter

Interface
REQ-001 Parameter GAP, default 1: number of idle cycles, 0..15, inserted after each frame's parity bit before the next grant.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Req0  input  1  requester 0 transmit request; level, held until Ack0.
REQ-005 Din0  input  8  requester 0 byte; stable while Req0 is high.
REQ-006 Req1  input  1  requester 1 transmit request; level, held until Ack1.
REQ-007 Din1  input  8  requester 1 byte; stable while Req1 is high.
REQ-008 Ack0  output  1  one-cycle pulse: Din0 captured.
REQ-009 Ack1  output  1  one-cycle pulse: Din1 captured.
REQ-010 SDout  output  1  serial line: data MSB first, then even-parity bit.
REQ-011 Frame  output  1  high for exactly the 9 bit-cycles of a frame.
REQ-012 GntId  output  1  owner of the current frame; valid while Frame=1.
REQ-013 Busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL use states IDLE, DATA, PAR and GAP.
REQ-015 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-016 IDLE: if Req0 or Req1 is sampled high at edge k, the block SHALL capture the granted byte and enter DATA, with Busy=1 from cycle k+1.
REQ-017 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; with one requesting, grant it.
REQ-018 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-019 The granted Ack SHALL be high in cycle k+1 only; the other Ack SHALL stay low.
REQ-020 GntId SHALL be set to the winner in cycle k+1.
REQ-021 DATA SHALL last 8 cycles, k+1..k+8, driving SDout = captured bit 7 down to bit 0, one bit per cycle.
REQ-022 PAR SHALL last 1 cycle, k+9, driving SDout = XOR of the 8 captured bits.
REQ-023 Frame SHALL be 1 in cycles k+1..k+9 and 0 otherwise.
REQ-024 GAP SHALL last GAP cycles, k+10..k+9+GAP, with SDout=0, Frame=0, Busy=1; then the block returns to IDLE.
REQ-025 With GAP=0, the block SHALL go from PAR directly to IDLE.
REQ-026 Requests SHALL be sampled only in IDLE; Req and Din changes in DATA, PAR or GAP SHALL have no effect.
REQ-027 A Req still high in the cycle its Ack is high SHALL NOT be treated as a new request.
REQ-028 A requester that keeps Req high after its Ack SHALL be re-granted only through normal arbitration in the next IDLE.
REQ-029 In IDLE, SDout=0, Frame=0 and Busy=0.
REQ-030 The earliest next grant edge after a frame granted at edge k SHALL be k+10+GAP, the first IDLE cycle.
REQ-031 A bit counter SHALL count 0..7 in DATA, clear on entry to PAR, and never wrap into a ninth data bit.
REQ-032 A gap counter SHALL count 0..GAP-1 and clear on exit from GAP.

Reset
REQ-033 While Rst_n=0, the block SHALL hold state IDLE, SDout=0, Frame=0, Busy=0, Ack0=0, Ack1=0, GntId=0, last-grant pointer=1, and counters=0.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately, with no further Ack, data bits or parity for it.
REQ-035 After Rst_n deasserts, the first grant SHALL be on the first rising edge with Rst_n=1 and a request sampled high.

Verification
REQ-036 Req0=1, Din0=8'hA5, GAP=1 -> Ack0 pulses at k+1; SDout k+1..k+9 = 1,0,1,0,0,1,0,1 then parity 0; Frame=1 for 9 cycles; Busy falls at k+11.
REQ-037 After reset, Req0=Req1=1 at the same edge, Din0=8'h01, Din1=8'h80, both held until acked -> frame 1 GntId=0 (bits 00000001, parity 1), frame 2 GntId=1 (bits 10000000, parity 1).
REQ-038 Both requesters held high for 4 frames -> GntId sequence 0,1,0,1; with GAP=2, each Frame rise is 12 cycles after the previous one.
REQ-039 GAP=0, Req1 held with Din1=8'hFF -> parity 0; Frame low for exactly 1 cycle (IDLE) between consecutive frames.
REQ-040 Rst_n pulled low at bit 4 of a frame -> SDout=0, Frame=0 and Busy=0 at once; after release with Req0=1, a fresh frame starts and Ack0 pulses once.
REQ-041 Din0 changed from 8'h3C to 8'hC3 mid-frame -> transmitted bits remain 00111100 with parity 0.
